hazard_scoreboard: RTL and testbench

Parametrised successor to the single-cycle load-use detector in the ID stage. Keeps a per-register countdown of cycles until an in-flight long-latency result (load, multiply, divide) can be forwarded. Stalls the instruction in IF/ID while any source register it reads is still pending. Also handles WAW overwrite, pipeline-wide memory stall, branch flush, and a saturating stall performance counter.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_lat_counter.sv | 29 ++
 rtl/hazard_scoreboard.sv | 80 ++++++++
 tb/tb_hazard_scoreboard.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and latency selection for the register hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_DIV  = 2'd3
  } cls_e;

  localparam int unsigned DEF_LOAD_LAT = 1;
  localparam int unsigned DEF_MUL_LAT  = 2;
  localparam int unsigned DEF_DIV_LAT  = 7;

  // Cycles a dependent must wait behind a producer of the given class.
  function automatic int unsigned lat_sel(input cls_e cls,
                                          input int unsigned load_lat,
                                          input int unsigned mul_lat,
                                          input int unsigned div_lat);
    unique case (cls)
      CLS_LOAD: lat_sel = load_lat;
      CLS_MUL:  lat_sel = mul_lat;
      CLS_DIV:  lat_sel = div_lat;
      default:  lat_sel = 0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_lat_counter.sv
// One per-register countdown: decrements toward zero, loads max(dec, lat), freezes on stall.
module hazard_lat_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             load_en,
  input  logic [LAT_W-1:0] load_lat,
  output logic [LAT_W-1:0] cnt
);

  logic [LAT_W-1:0] dec;
  logic [LAT_W-1:0] cnt_next;

  always_comb begin
    dec      = (cnt != '0) ? cnt - LAT_W'(1) : '0;
    cnt_next = dec;
    // A newer write never shortens an outstanding wait (WAW keeps the longer one).
    if (load_en && (load_lat > dec)) cnt_next = load_lat;
  end

  // NOTE: sequential state uses non-blocking assignment so every counter samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (!freeze) cnt <= cnt_next;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: per-register pending countdowns, stall/bubble generation, stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_AW      = 5,
  parameter int LAT_W       = 3,
  parameter int LOAD_LAT    = DEF_LOAD_LAT,
  parameter int MUL_LAT     = DEF_MUL_LAT,
  parameter int DIV_LAT     = DEF_DIV_LAT,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   IFID_Valid_i,
  input  logic [REG_AW-1:0]      IFID_RS1_i,
  input  logic [REG_AW-1:0]      IFID_RS2_i,
  input  logic                   IFID_UseRS1_i,
  input  logic                   IFID_UseRS2_i,
  input  logic [REG_AW-1:0]      IFID_RD_i,
  input  logic                   IFID_RegWrite_i,
  input  logic [1:0]             IFID_Class_i,
  input  logic                   Flush_i,
  input  logic                   MemStall_i,
  output logic                   PCWrite_o,
  output logic                   Stall_o,
  output logic                   NoOp_o,
  output logic [STALL_CNT_W-1:0] StallCnt_o,
  output logic [NUM_REGS-1:0]    Pending_o
);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic             haz;
  logic             issue;
  logic [LAT_W-1:0] lat;

  // Register 0 is hard-wired zero, so it can never be pending.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    hazard_lat_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clk_i),
      .rst      (rst_i),
      .freeze   (MemStall_i),
      .load_en  (issue && (IFID_RD_i == REG_AW'(r))),
      .load_lat (lat),
      .cnt      (cnt[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) pending[r] = (cnt[r] != '0);
  end

  assign Pending_o = pending;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    haz = IFID_Valid_i && !Flush_i &&
          ((IFID_UseRS1_i && pending[IFID_RS1_i]) ||
           (IFID_UseRS2_i && pending[IFID_RS2_i]));
    issue = IFID_Valid_i && !haz && !Flush_i && !MemStall_i &&
            IFID_RegWrite_i && (IFID_RD_i != '0);
    lat = LAT_W'(lat_sel(cls_e'(IFID_Class_i), LOAD_LAT, MUL_LAT, DIV_LAT));
  end

  // A frozen pipeline still shows the stall but does not count it.
  assign Stall_o   = haz;
  assign NoOp_o    = haz;
  assign PCWrite_o = !haz;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      StallCnt_o <= '0;
    else if (haz && !MemStall_i && (StallCnt_o != '1))
      StallCnt_o <= StallCnt_o + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (plus a 4-bit counter instance for saturation).
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        use1 = 1'b0, use2 = 1'b0, regw = 1'b0;
  logic [1:0]  cls = 2'd0;
  logic        flush = 1'b0, mstall = 1'b0;

  logic        pcw, stall, noop;
  logic [15:0] scnt;
  logic [31:0] pend;
  logic        s_pcw, s_stall, s_noop;
  logic [3:0]  s_scnt;
  logic [31:0] s_pend;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .IFID_Valid_i(valid), .IFID_RS1_i(rs1), .IFID_RS2_i(rs2),
    .IFID_UseRS1_i(use1), .IFID_UseRS2_i(use2), .IFID_RD_i(rd), .IFID_RegWrite_i(regw),
    .IFID_Class_i(cls), .Flush_i(flush), .MemStall_i(mstall), .PCWrite_o(pcw),
    .Stall_o(stall), .NoOp_o(noop), .StallCnt_o(scnt), .Pending_o(pend)
  );

  hazard_scoreboard #(.STALL_CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .IFID_Valid_i(valid), .IFID_RS1_i(rs1), .IFID_RS2_i(rs2),
    .IFID_UseRS1_i(use1), .IFID_UseRS2_i(use2), .IFID_RD_i(rd), .IFID_RegWrite_i(regw),
    .IFID_Class_i(cls), .Flush_i(flush), .MemStall_i(mstall), .PCWrite_o(s_pcw),
    .Stall_o(s_stall), .NoOp_o(s_noop), .StallCnt_o(s_scnt), .Pending_o(s_pend)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    valid = 1'b0; regw = 1'b0; use1 = 1'b0; use2 = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; cls = 2'd0; flush = 1'b0; mstall = 1'b0;
  endtask

  // Called at posedge+1; asynchronous pulse, then realign to posedge+1.
  task automatic do_reset();
    go_idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic issue_op(input logic [1:0] c, input logic [4:0] d);
    valid = 1'b1; regw = 1'b1; cls = c; rd = d; use1 = 1'b0; use2 = 1'b0;
    @(posedge clk); #1;
    go_idle();
  endtask

  // Holds a non-writing dependent in IF/ID and counts the cycles it is stalled.
  task automatic count_stall(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                             input logic u2, input int ms_start, input int ms_len,
                             output int cycles);
    valid = 1'b1; regw = 1'b0; rs1 = r1; use1 = u1; rs2 = r2; use2 = u2;
    cycles = 0;
    for (int i = 0; i < 30; i++) begin
      mstall = (i >= ms_start) && (i < ms_start + ms_len);
      @(negedge clk);
      if (!stall) break;
      cycles++;
      @(posedge clk); #1;
    end
    mstall = 1'b0;
    @(posedge clk); #1;
    go_idle();
  endtask

  initial begin
    // Reset state while rst is held
    #2;
    check("rst_pcwrite", 32'(pcw), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_noop", 32'(noop), 32'd0);
    check("rst_pending", pend, 32'd0);
    check("rst_stallcnt", 32'(scnt), 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Load-use: one bubble
    issue_op(CLS_LOAD, 5'd5);
    valid = 1'b1; rs1 = 5'd5; use1 = 1'b1;
    @(negedge clk);
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_noop", 32'(noop), 32'd1);
    check("lu_pcwrite", 32'(pcw), 32'd0);
    check("lu_pend5", 32'(pend[5]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("lu_release", 32'(stall), 32'd0);
    check("lu_pcw_rel", 32'(pcw), 32'd1);
    @(posedge clk); #1;
    go_idle();
    check("lu_stallcnt", 32'(scnt), 32'd1);

    // Divide chain via RS2
    do_reset();
    issue_op(CLS_DIV, 5'd3);
    check("div_pend3", 32'(pend[3]), 32'd1);
    count_stall(5'd0, 1'b0, 5'd3, 1'b1, 0, 0, n);
    check("div_len", 32'(n), 32'd7);
    check("div_pend3_off", 32'(pend[3]), 32'd0);
    check("div_stallcnt", 32'(scnt), 32'd7);

    // WAW: DIV then LOAD to same RD keeps the longer wait (6)
    do_reset();
    issue_op(CLS_DIV, 5'd4);
    issue_op(CLS_LOAD, 5'd4);
    count_stall(5'd4, 1'b1, 5'd0, 1'b0, 0, 0, n);
    check("waw_len", 32'(n), 32'd6);

    // ALU write cannot shorten an outstanding MUL wait
    do_reset();
    issue_op(CLS_MUL, 5'd7);
    issue_op(CLS_ALU, 5'd7);
    count_stall(5'd7, 1'b1, 5'd0, 1'b0, 0, 0, n);
    check("alu_noshort", 32'(n), 32'd1);

    // x0 never becomes pending
    do_reset();
    issue_op(CLS_LOAD, 5'd0);
    @(negedge clk);
    check("x0_pending", pend, 32'd0);
    @(posedge clk); #1;
    count_stall(5'd0, 1'b1, 5'd0, 1'b1, 0, 0, n);
    check("x0_nostall", 32'(n), 32'd0);

    // MemStall for 3 cycles during a MUL wait: 2+3 visible, 2 counted
    do_reset();
    issue_op(CLS_MUL, 5'd6);
    count_stall(5'd6, 1'b1, 5'd0, 1'b0, 1, 3, n);
    check("ms_len", 32'(n), 32'd5);
    check("ms_stallcnt", 32'(scnt), 32'd2);

    // Flush: no stall that cycle, counter still decrements
    do_reset();
    issue_op(CLS_LOAD, 5'd5);
    valid = 1'b1; rs1 = 5'd5; use1 = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("fl_stall", 32'(stall), 32'd0);
    check("fl_pcwrite", 32'(pcw), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_after", 32'(stall), 32'd0);
    check("fl_pending", pend, 32'd0);
    @(posedge clk); #1;
    go_idle();
    check("fl_stallcnt", 32'(scnt), 32'd0);

    // Async reset mid-DIV wait (cnt=4 after three stalled edges)
    do_reset();
    issue_op(CLS_DIV, 5'd2);
    valid = 1'b1; rs1 = 5'd2; use1 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("ar_pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_stall", 32'(stall), 32'd0);
    check("ar_noop", 32'(noop), 32'd0);
    check("ar_pcwrite", 32'(pcw), 32'd1);
    check("ar_pending", pend, 32'd0);
    check("ar_stallcnt", 32'(scnt), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ar_proceed", 32'(stall), 32'd0);
    @(posedge clk); #1;
    go_idle();

    // Saturation: 21 stall cycles, 4-bit counter pins at 15
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue_op(CLS_DIV, 5'd1);
      count_stall(5'd1, 1'b1, 5'd0, 1'b0, 0, 0, n);
      check("sat_len", 32'(n), 32'd7);
    end
    check("sat_wide", 32'(scnt), 32'd21);
    check("sat_narrow", 32'(s_scnt), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
